// File: rtl/mio_bus_arbiter_pkg.sv
// mio_defs: arbiter state encodings and default bus/latency constants
package mio_defs;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_VGA  = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_LAT_DEF   = 2;
  localparam int VGA_BURST_DEF = 8;
endpackage

// File: rtl/mio_wait_counter.sv
// mio_wait_counter: counts bus-active cycles of one access; done marks the last one
//   clk, reset (async, active-low), load (clear at grant), en (count while accessing), done
module mio_wait_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign done = cnt == W'(MEM_LAT - 1);
endmodule

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one memory/IO bus between CPU and VGA fetch with fixed-latency accesses
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, MIO_ready (one-cycle completion)
//   vga_req/vga_addr -> vga_rdata, vga_ack (one-cycle completion)
//   mem_ce/mem_we/mem_addr/mem_wdata, mem_rdata: bus side; arb_state: FSM state for debug
//   ARB_STATS_EN adds cpu_stall_cnt (cycles the CPU waits, saturating)
module mio_bus_arbiter
  import mio_defs::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int VGA_BURST = VGA_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              MIO_ready,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_state
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);
  localparam int BW = $clog2(VGA_BURST + 1);
  arb_state_e state, state_nxt;
  logic vga_own, grant_vga, grant_cpu, acc, lat_done;
  logic [BW-1:0] burst_cnt;
  assign acc = state == ARB_CPU || state == ARB_VGA;
  // VGA keeps priority until it has taken VGA_BURST grants in a row over a waiting CPU
  assign grant_vga = state == ARB_IDLE && vga_req && (!cpu_req || burst_cnt < BW'(VGA_BURST));
  assign grant_cpu = state == ARB_IDLE && cpu_req && !grant_vga;
  mio_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk(clk),
    .reset(reset),
    .load(grant_vga || grant_cpu),
    .en(acc),
    .done(lat_done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ARB_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == ARB_IDLE ? (grant_vga ? ARB_VGA : grant_cpu ? ARB_CPU : ARB_IDLE) :
                acc ? (lat_done ? ARB_DONE : state) : ARB_IDLE;
  always_comb begin
    arb_state = state;
    MIO_ready = state == ARB_DONE && !vga_own;
    vga_ack   = state == ARB_DONE && vga_own;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      vga_own   <= 1'b0;
      burst_cnt <= '0;
    end else if (grant_vga || grant_cpu) begin
      mem_ce   <= 1'b1;
      mem_we   <= grant_cpu && cpu_we;
      mem_addr <= grant_vga ? vga_addr : cpu_addr;
      vga_own  <= grant_vga;
      if (grant_cpu && cpu_we) mem_wdata <= cpu_wdata;
      burst_cnt <= grant_cpu || !cpu_req ? '0 :
                   burst_cnt == BW'(VGA_BURST) ? burst_cnt : burst_cnt + 1'b1;
    end else if (acc && lat_done) begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      if (vga_own) vga_rdata <= mem_rdata;
      else if (!mem_we) cpu_rdata <= mem_rdata;
    end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) cpu_stall_cnt <= '0;
    else if (cpu_req && !MIO_ready && cpu_stall_cnt != 16'hFFFF) cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
`endif
endmodule
